boolean_function_sweeper: RTL and testbench

Sequencer that exhaustively exercises a 3-input combinational boolean-function block in hardware. On `start` it drives the eight input combinations onto `a`, `b`, `c`, holds each for a programmable settle time, and samples the function output `y` into an 8-bit truth table. It then compares the table against an expected constant and reports pass/fail, the mismatch count and the first failing index. It sits between a board-level start button or debug controller and the boolean-function instance under test.

---
 rtl/boolean_function_sweeper.sv | 142 ++++++++++++++
 tb/tb_boolean_function_sweeper.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/boolean_function_sweeper.sv
// boolean_function_sweeper
//   Drives the eight {a,b,c} combinations onto a 3-input combinational
//   function. Each combination is held for HOLD_CYCLES clocks and y is
//   then sampled into a working truth table. When the sweep completes,
//   the table is compared against EXPECTED and the result registers are
//   loaded.
//
// Parameters
//   HOLD_CYCLES  cycles each vector is held before y is sampled (1..15)
//   EXPECTED     expected truth table; bit i is y for {a,b,c} = i
//
// Ports
//   clk, rst_n      clock; asynchronous active-low reset
//   start           sweep request, accepted only when idle
//   y               output of the function under test
//   a, b, c         function inputs (a = MSB of the vector index)
//   busy            high while vectors are being applied
//   done            one-cycle pulse on the cycle the results update
//   truth_table     table captured by the last completed sweep
//   pass            truth_table == EXPECTED
//   mismatch_count  popcount(truth_table ^ EXPECTED)
//   first_fail_idx  lowest differing index (0 when pass)
module boolean_function_sweeper #(
    parameter int         HOLD_CYCLES = 2,
    parameter logic [7:0] EXPECTED    = 8'hEA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       pass,
    output logic [3:0] mismatch_count,
    output logic [2:0] first_fail_idx
);

    // hcnt only has to reach HOLD_CYCLES-1, so it needs at least one bit.
    localparam int            HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [HW-1:0] hcnt, hcnt_nxt;
    logic [7:0]    work, work_nxt;
    logic          sample;
    logic          load;
    logic [7:0]    diff;

    function automatic logic [3:0] popcnt8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] f;
        f = '0;
        for (int i = 7; i >= 0; i--) if (v[i]) f = 3'(i);
        return f;
    endfunction

    // The sample edge is the last cycle of a vector's hold window.
    assign sample = (state == APPLY) && (hcnt == HLAST);
    // On the final sample the results are taken from work_nxt. That way
    // bit 7, sampled on the same edge, is included.
    assign load   = sample && (idx == 3'd7);
    assign diff   = work_nxt ^ EXPECTED;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        hcnt_nxt  = hcnt;
        work_nxt  = work;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = APPLY;
                    idx_nxt   = '0;
                    hcnt_nxt  = '0;
                end
            end
            APPLY: begin
                if (!sample) begin
                    hcnt_nxt = hcnt + 1'b1;
                end else begin
                    work_nxt[idx] = y;
                    if (idx == 3'd7) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt  = idx + 3'd1;
                        hcnt_nxt = '0;
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            hcnt  <= '0;
            work  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            hcnt  <= hcnt_nxt;
            work  <= work_nxt;
        end
    end

    // The result registers only change at completion. They hold through
    // later starts, so a partially filled table is never visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            truth_table    <= '0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            first_fail_idx <= '0;
        end else if (load) begin
            truth_table    <= work_nxt;
            pass           <= (diff == 8'h00);
            mismatch_count <= popcnt8(diff);
            first_fail_idx <= lowest_set(diff);
        end
    end

    assign {a, b, c} = (state == APPLY) ? idx : 3'b000;
    assign busy      = (state == APPLY);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_boolean_function_sweeper.sv
module tb_boolean_function_sweeper;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;             // 0: HOLD_CYCLES=2 instance, 1: HOLD_CYCLES=1 instance
    logic mode0 = 1'b0, mode1 = 1'b0;  // 0: y=(a&b)|c, 1: y=a^b^c

    logic a0, b0, c0, busy0, done0, pass0, y0;
    logic a1, b1, c1, busy1, done1, pass1, y1;
    logic [7:0] tt0, tt1;
    logic [3:0] mm0, mm1;
    logic [2:0] ff0, ff1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Behavioural models of the function under test.
    assign y0 = mode0 ? (a0 ^ b0 ^ c0) : ((a0 & b0) | c0);
    assign y1 = mode1 ? (a1 ^ b1 ^ c1) : ((a1 & b1) | c1);

    boolean_function_sweeper #(.HOLD_CYCLES(2), .EXPECTED(8'hEA)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .y(y0),
        .a(a0), .b(b0), .c(c0), .busy(busy0), .done(done0),
        .truth_table(tt0), .pass(pass0), .mismatch_count(mm0), .first_fail_idx(ff0));

    boolean_function_sweeper #(.HOLD_CYCLES(1), .EXPECTED(8'hEA)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .y(y1),
        .a(a1), .b(b1), .c(c1), .busy(busy1), .done(done1),
        .truth_table(tt1), .pass(pass1), .mismatch_count(mm1), .first_fail_idx(ff1));

    // Outputs of the selected instance
    wire [2:0] abc  = sel ? {a1, b1, c1} : {a0, b0, c0};
    wire       busy = sel ? busy1 : busy0;
    wire       done = sel ? done1 : done0;
    wire [7:0] tt   = sel ? tt1 : tt0;
    wire       pass = sel ? pass1 : pass0;
    wire [3:0] mm   = sel ? mm1 : mm0;
    wire [2:0] ff   = sel ? ff1 : ff0;

    typedef struct {
        logic       sel;
        logic       mode;
        int         hold;
        logic [7:0] tt;
        logic       pass;
        logic [3:0] mm;
        logic [2:0] ff;
    } vec_t;

    vec_t vt[4];

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Sweep on the selected instance. E0 is the edge that samples start.
    // extra_at > 0 raises start again so that it is sampled at edge
    // E0+extra_at. The loop is bounded, so a missing done shows up as
    // done_k = -1.
    task automatic sweep(input int hold, input int extra_at,
                         output int done_k, output int ndone,
                         output int nbusy, output int abc_err);
        int n;
        n = 8 * hold + 12;
        done_k = -1; ndone = 0; nbusy = 0; abc_err = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;       // E0
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (k == extra_at) start = 1'b0;
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_k < 0) done_k = k;
            end
            if (k < 8 * hold && abc != 3'(k / hold)) abc_err++;
            if (k >= 8 * hold && abc != 3'b000) abc_err++;
            if (extra_at > 0 && k == extra_at - 1) begin
                @(negedge clk); start = 1'b1;
            end
        end
    endtask

    initial begin
        int dk, nd, nb, ae;

        vt[0] = '{1'b0, 1'b0, 2, 8'hEA, 1'b1, 4'd0, 3'd0};
        vt[1] = '{1'b0, 1'b1, 2, 8'h96, 1'b0, 4'd5, 3'd2};
        vt[2] = '{1'b1, 1'b0, 1, 8'hEA, 1'b1, 4'd0, 3'd0};
        vt[3] = '{1'b1, 1'b1, 1, 8'h96, 1'b0, 4'd5, 3'd2};

        // Asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        chk("reset_abc", {a0, b0, c0}, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_tt", tt0, 8'h00);
        chk("reset_pass", pass0, 0);
        chk("reset_tt_h1", tt1, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven sweeps
        for (int i = 0; i < 4; i++) begin
            sel = vt[i].sel;
            if (vt[i].sel) mode1 = vt[i].mode; else mode0 = vt[i].mode;
            sweep(vt[i].hold, 0, dk, nd, nb, ae);
            chk($sformatf("v%0d_done_cycle", i), dk, 8 * vt[i].hold);
            chk($sformatf("v%0d_done_count", i), nd, 1);
            chk($sformatf("v%0d_busy_cycles", i), nb, 8 * vt[i].hold);
            chk($sformatf("v%0d_abc_seq_errs", i), ae, 0);
            chk($sformatf("v%0d_truth_table", i), tt, vt[i].tt);
            chk($sformatf("v%0d_pass", i), pass, vt[i].pass);
            chk($sformatf("v%0d_mismatch_count", i), mm, vt[i].mm);
            chk($sformatf("v%0d_first_fail_idx", i), ff, vt[i].ff);
            repeat (2) @(posedge clk);
        end

        // A start sampled at E0+5 during busy must be ignored
        sel = 1'b0; mode0 = 1'b0;
        sweep(2, 5, dk, nd, nb, ae);
        chk("busy_start_done_cycle", dk, 16);
        chk("busy_start_done_count", nd, 1);
        chk("busy_start_busy_cycles", nb, 16);
        chk("busy_start_tt", tt, 8'hEA);

        // Leave 8'h96 behind, then abort the next sweep at E0+7
        mode0 = 1'b1;
        sweep(2, 0, dk, nd, nb, ae);
        chk("pre_abort_tt", tt0, 8'h96);
        mode0 = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;        // E0
        repeat (7) @(posedge clk);               // E0+7
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy0, 0);
        chk("abort_abc", {a0, b0, c0}, 0);
        chk("abort_tt", tt0, 8'h00);
        chk("abort_pass", pass0, 0);
        chk("abort_mm", mm0, 0);
        chk("abort_ff", ff0, 0);
        nd = 0;
        repeat (2) begin @(posedge clk); #1; if (done0) nd++; end
        @(negedge clk) rst_n = 1'b1;
        repeat (20) begin @(posedge clk); #1; if (done0 || busy0) nd++; end
        chk("abort_no_done", nd, 0);

        // A fresh sweep after the abort completes normally
        sweep(2, 0, dk, nd, nb, ae);
        chk("after_abort_done_cycle", dk, 16);
        chk("after_abort_tt", tt0, 8'hEA);
        chk("after_abort_pass", pass0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
